// File: rtl/regfile_mp.sv
// Multi-port register file with a hardwired zero register, zero-cycle
// write-to-read bypass and a per-register pending (scoreboard) bit.
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NREAD    = 2,
  parameter int ZERO_REG = DEPTH - 1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [NREAD*AW-1:0]    RA,
  output logic [NREAD*WIDTH-1:0] BusR,
  output logic [NREAD-1:0]       Rdy,
  input  logic                   RegWr0,
  input  logic [AW-1:0]          RW0,
  input  logic [WIDTH-1:0]       BusW0,
  input  logic                   RegWr1,
  input  logic [AW-1:0]          RW1,
  input  logic [WIDTH-1:0]       BusW1,
  input  logic                   RsvEn,
  input  logic [AW-1:0]          RsvReg,
  output logic [AW:0]            PendCnt
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr0_ok, wr1_ok, rsv_ok;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + (AW+1)'(v[i]);
    return n;
  endfunction

  assign wr0_ok = RegWr0 && (RW0 != ZR);
  assign wr1_ok = RegWr1 && (RW1 != ZR);
  assign rsv_ok = RsvEn && (RsvReg != ZR);

  // Reserve is applied after the write clears so a same-cycle reserve wins.
  always_comb begin
    pend_d = pend_q;
    if (wr0_ok) pend_d[RW0] = 1'b0;
    if (wr1_ok) pend_d[RW1] = 1'b0;
    if (rsv_ok) pend_d[RsvReg] = 1'b1;
    cnt_d = popcount(pend_d);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr0_ok) mem_q[RW0] <= BusW0;
      if (wr1_ok) mem_q[RW1] <= BusW1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign PendCnt = cnt_q;

  // Read ports: port 1 bypass has priority over port 0, then the array.
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit0, hit1;
    assign ra   = RA[g*AW +: AW];
    assign hit0 = wr0_ok && (RW0 == ra);
    assign hit1 = wr1_ok && (RW1 == ra);
    assign BusR[g*WIDTH +: WIDTH] = (ra == ZR) ? '0 :
                                    hit1       ? BusW1 :
                                    hit0       ? BusW0 : mem_q[ra];
    assign Rdy[g] = (ra == ZR) || !pend_q[ra] || hit0 || hit1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomized bench for regfile_mp against an array-based model.
module tb_regfile_mp;
  localparam int W = 64, D = 32, A = 5, NR = 2, ZREG = 31;

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic [NR*A-1:0] RA;
  logic [NR*W-1:0] BusR;
  logic [NR-1:0]   Rdy;
  logic            RegWr0, RegWr1, RsvEn;
  logic [A-1:0]    RW0, RW1, RsvReg;
  logic [W-1:0]    BusW0, BusW1;
  logic [A:0]      PendCnt;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_mem [D];
  bit           m_pend [D];

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_REG(ZREG)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .BusR(BusR), .Rdy(Rdy),
    .RegWr0(RegWr0), .RW0(RW0), .BusW0(BusW0),
    .RegWr1(RegWr1), .RW1(RW1), .BusW1(BusW1),
    .RsvEn(RsvEn), .RsvReg(RsvReg), .PendCnt(PendCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic bit written(input int a);
    return (RegWr0 && int'(RW0) == a && a != ZREG) || (RegWr1 && int'(RW1) == a && a != ZREG);
  endfunction

  function automatic logic [W-1:0] exp_data(input int a);
    if (a == ZREG) return '0;
    if (RegWr1 && int'(RW1) == a) return BusW1;
    if (RegWr0 && int'(RW0) == a) return BusW0;
    return m_mem[a];
  endfunction

  task automatic check_all(input string tag);
    for (int p = 0; p < NR; p++) begin
      int a = int'(RA[p*A +: A]);
      chk({tag, "_bus"}, BusR[p*W +: W], exp_data(a));
      chk({tag, "_rdy"}, W'(Rdy[p]), W'((a == ZREG) || !m_pend[a] || written(a)));
    end
    chk({tag, "_cnt"}, W'(PendCnt), W'(model_cnt()));
  endtask

  task automatic set_in(input logic w0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                        input logic w1, input logic [A-1:0] a1, input logic [W-1:0] d1,
                        input logic rs, input logic [A-1:0] rr,
                        input logic [A-1:0] r0, input logic [A-1:0] r1);
    RegWr0 = w0; RW0 = a0; BusW0 = d0;
    RegWr1 = w1; RW1 = a1; BusW1 = d1;
    RsvEn = rs; RsvReg = rr;
    RA = {r1, r0};
    #1;
  endtask

  // Advance one edge; the model applies the same inputs the DUT sampled.
  task automatic tick();
    @(posedge Clk);
    if (RegWr0 && int'(RW0) != ZREG) begin m_mem[RW0] = BusW0; m_pend[RW0] = 1'b0; end
    if (RegWr1 && int'(RW1) != ZREG) begin m_mem[RW1] = BusW1; m_pend[RW1] = 1'b0; end
    if (RsvEn && int'(RsvReg) != ZREG) m_pend[RsvReg] = 1'b1;
    #1;
  endtask

  initial begin
    model_reset();
    Rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_bus0", BusR[W-1:0], 64'h0);
    chk("rst_rdy", W'(Rdy), W'(2'b11));
    chk("rst_cnt", W'(PendCnt), 64'h0);
    #1 Rst_n = 1'b1;

    // write R3 and reserve R4, then assert reset between edges
    set_in(1, 3, 64'h55, 0, 0, 0, 1, 4, 3, 4);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    chk("r3_stored", BusR[W-1:0], 64'h55);
    chk("r4_pending", W'(Rdy[1]), 64'h0);
    chk("cnt_one", W'(PendCnt), 64'h1);
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_bus", BusR[W-1:0], 64'h0);
    chk("async_rst_rdy", W'(Rdy), W'(2'b11));
    chk("async_rst_cnt", W'(PendCnt), 64'h0);
    #1 Rst_n = 1'b1;

    set_in(1, 5, 64'hDEAD, 0, 0, 0, 0, 0, 5, 0);
    chk("bypass_w0", BusR[W-1:0], 64'hDEAD);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("stored_r5", BusR[W-1:0], 64'hDEAD);

    set_in(1, 7, 64'h1, 1, 7, 64'h2, 0, 0, 7, 7);
    chk("dual_bypass", BusR[W-1:0], 64'h2);
    tick();
    set_in(1, 8, 64'h88, 1, 9, 64'h99, 0, 0, 7, 8);
    chk("dual_stored", BusR[W-1:0], 64'h2);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 8, 9);
    chk("w0_r8", BusR[W-1:0], 64'h88);
    chk("w1_r9", BusR[2*W-1:W], 64'h99);

    set_in(1, 31, 64'hFFFF, 1, 31, 64'hFFFF, 1, 31, 31, 31);
    chk("zero_bus", BusR[W-1:0], 64'h0);
    chk("zero_rdy", W'(Rdy), W'(2'b11));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 31, 31);
    chk("zero_after_bus", BusR[2*W-1:W], 64'h0);
    chk("zero_cnt", W'(PendCnt), 64'h0);

    set_in(0, 0, 0, 0, 0, 0, 1, 10, 10, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
    chk("rsv10_rdy", W'(Rdy[0]), 64'h0);
    chk("rsv10_cnt", W'(PendCnt), 64'h1);
    set_in(1, 10, 64'hA, 0, 0, 0, 0, 0, 10, 0);
    chk("wr10_bypass_rdy", W'(Rdy[0]), 64'h1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
    chk("wr10_cnt", W'(PendCnt), 64'h0);
    chk("wr10_rdy", W'(Rdy[0]), 64'h1);
    set_in(0, 0, 0, 1, 10, 64'hB, 1, 10, 10, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
    chk("wr_rsv10_rdy", W'(Rdy[0]), 64'h0);
    chk("wr_rsv10_bus", BusR[W-1:0], 64'hB);
    chk("wr_rsv10_cnt", W'(PendCnt), 64'h1);

    for (int r = 0; r < 31; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, A'(r), A'(r), 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 30);
    chk("fill_cnt", W'(PendCnt), 64'd31);
    chk("fill_rdy", W'(Rdy), 64'h0);
    for (int k = 0; k < 16; k++) begin
      set_in(1, A'(2*k), W'(k), 1, A'(2*k+1), W'(k+100), 0, 0, A'(2*k), A'(2*k+1));
      check_all("drain");
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 30);
    chk("drain_cnt", W'(PendCnt), 64'h0);
    chk("drain_r30", BusR[2*W-1:W], 64'd15);

    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), A'($urandom_range(0, 31)), {$urandom, $urandom},
             1'($urandom_range(0, 1)), A'($urandom_range(0, 31)), {$urandom, $urandom},
             1'($urandom_range(0, 2) == 0), A'($urandom_range(0, 31)),
             A'($urandom_range(0, 31)), A'($urandom_range(0, 31)));
      check_all("rand");
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_all("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
